// File: rtl/sr_pkg.sv
// Shared types and the per-bit next-state function for the sr_reg_bank SR flop bank.
package sr_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_SET_DOM = 2'd1,
    SR_RST_DOM = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  // Next state of one enabled, non-cleared bit; mode only matters when s=r=1.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_e mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b00:   nxt = q;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      default: begin
        case (mode)
          SR_HOLD:    nxt = q;
          SR_SET_DOM: nxt = 1'b1;
          SR_RST_DOM: nxt = 1'b0;
          default:    nxt = ~q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR channel: registered q, complementary qbar and one-cycle rise/fall pulses.
module sr_cell
  import sr_pkg::*;
#(
  parameter logic     RESET_VAL = 1'b0,
  parameter sr_mode_e MODE      = SR_RST_DOM
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar,
  output logic rose,
  output logic fell
);

  logic q_d, q_q;
  logic qbar_d, qbar_q;
  logic rose_d, rose_q;
  logic fell_d, fell_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RESET_VAL;
    end else if (en) begin
      q_d = sr_next(q_q, s, r, MODE);
    end
    qbar_d = ~q_d;
    rose_d = q_d & ~q_q;
    fell_d = ~q_d & q_q;
  end

  // qbar has its own flop so it is a clean register output, not an inverter after q.
  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      qbar_q <= ~RESET_VAL;
      rose_q <= 1'b0;
      fell_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      qbar_q <= qbar_d;
      rose_q <= rose_d;
      fell_q <= fell_d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
  assign rose = rose_q;
  assign fell = fell_q;

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH SR flops with conflict detection; define SR_REG_BANK_CONFLICT_CNT_EN
// to build the saturating conflict counter (otherwise conflict_cnt is tied to 0).
module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0,
  parameter int               CONFLICT_MODE = 2,
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rose,
  output logic [WIDTH-1:0] fell,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
    $error("sr_reg_bank: CONFLICT_MODE must be 0..3");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_reg_bank: WIDTH must be 1..64");
  end

  localparam sr_mode_e MODE_E = sr_mode_e'(CONFLICT_MODE[1:0]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_cell #(
      .RESET_VAL (RESET_VAL[i]),
      .MODE      (MODE_E)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (en),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i]),
      .qbar (qbar[i]),
      .rose (rose[i]),
      .fell (fell[i])
    );
  end

  // One event per cycle no matter how many bits conflict; clr or en=0 masks it.
  logic conflict_evt;
  assign conflict_evt = en & ~clr & (|(s & r));

  logic sticky_d, sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (conflict_evt) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign conflict_sticky = sticky_q;

`ifdef SR_REG_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // err_clr restarts the count, so a simultaneous event becomes the first one counted.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = conflict_evt ? CNT_W'(1) : '0;
    end else if (conflict_evt && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: doc/sr_reg_bank.md
# sr_reg_bank

Parametrised bank of `WIDTH` independent set/reset flip-flops sharing one clock and reset. Each bit has a compile-time conflict policy for s=r=1, plus registered complementary outputs, rising/falling edge pulses and conflict error reporting. It replaces single-bit SR flops wherever status or flag bits are set and cleared by separate event sources, such as interrupt pending bits and sticky status registers.

## Interface
- `WIDTH`, 8: number of SR channels, 1..64.
- `RESET_VAL`, all-zeros: per-bit value of `q` after `rst` or `clr`.
- `CONFLICT_MODE`, 2: action when s=r=1 on a bit. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- `CNT_W`, 8: width of the conflict counter.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `clr` in 1: synchronous clear of all bits to `RESET_VAL`.
- `en` in 1: update enable; when low, `q` holds.
- `s` in WIDTH: per-bit set.
- `r` in WIDTH: per-bit reset.
- `err_clr` in 1: synchronous clear of `conflict_sticky` and `conflict_cnt`.
- `q` out WIDTH: registered state.
- `qbar` out WIDTH: registered, always exactly `~q`; never high-Z or X after reset.
- `rose` out WIDTH: one-cycle pulse when a bit of `q` changes 0→1.
- `fell` out WIDTH: one-cycle pulse when a bit of `q` changes 1→0.
- `conflict_sticky` out 1: set on any conflict; held until `err_clr`.
- `conflict_cnt` out CNT_W: saturating count of conflict cycles (only when macro defined).

## Operation
- Per-bit next state, evaluated in priority order:
  1. `rst` forces the bit to `RESET_VAL`.
  2. `clr` forces the bit to `RESET_VAL`.
  3. `en=0`: hold.
  4. s/r = 00: hold.
  5. s/r = 01: 0.
  6. s/r = 10: 1.
  7. s/r = 11: result set by `CONFLICT_MODE`.
- Conflict event: `en=1`, `clr=0`, and (s & r) nonzero. A conflict cycle is counted once, regardless of how many bits conflict.
- `conflict_sticky`: set on a conflict event. `err_clr` clears it. If `err_clr` and a conflict event fall in the same cycle, the event wins and the result is sticky=1.
- `conflict_cnt`: +1 per conflict event, saturating at all-ones. `err_clr` loads 0. If `err_clr` and a conflict event fall in the same cycle, the counter loads 1.
- `rose` = q_next & ~q, registered. `fell` = ~q_next & q, registered. Changes caused by `clr` do produce pulses. Changes caused by `rst` do not.
- Undefined `CONFLICT_MODE` values are an elaboration error.

## Timing
- Latency: inputs are sampled at rising edge k; `q`, `qbar`, `rose`, `fell` and the error outputs update after edge k. There is no combinational path from input to output.
- Reset values:
  - `q` = `RESET_VAL`
  - `qbar` = ~`RESET_VAL`
  - `rose` = `fell` = 0
  - `conflict_sticky` = 0
  - `conflict_cnt` = 0
- Reset asserted mid-operation: all outputs take their reset values immediately and asynchronously. After deassertion, the first edge behaves normally.
- Pulses last exactly one cycle. A bit held at a constant value gives no pulse.
- Toggle mode with s=r=1 held: `q` alternates every enabled cycle, and `rose`/`fell` alternate.

## Configuration
- `SR_REG_BANK_CONFLICT_CNT_EN`
  - Defined: `conflict_cnt` is a CNT_W-bit saturating counter as specified above.
  - Undefined: the counter register is removed and `conflict_cnt` is tied to 0; `conflict_sticky` is unaffected.

## Structure
- Package `sr_pkg`:
  - conflict mode constants: `SR_HOLD`, `SR_SET_DOM`, `SR_RST_DOM`, `SR_TOGGLE`
  - a function computing the next state of one bit from (q, s, r, mode)
- Sub-module `sr_cell`: one bit holding q, qbar and the edge-pulse registers. It is instantiated WIDTH times by a generate loop.
- The top level holds the conflict detect OR-reduction, the sticky flag and the counter.

## Test plan
1. WIDTH=8, RESET_VAL=8'h0F: assert `rst`, then release.
   - Expect q=0F, qbar=F0 and all other outputs 0.
   - Then drive `clr` with s=FF → q stays 0F and no pulses occur.
2. en=1, s=8'h30, r=8'h01 for one cycle.
   - Expect q=3E, rose=30, fell=01 for exactly one cycle.
   - Then s=r=0 → q holds at 3E and pulses are 0.
3. Conflict-mode sweep with s=r=8'h80 and q[7]=0, one build per mode:
   - mode 0 → q[7]=0
   - mode 1 → q[7]=1
   - mode 2 → q[7]=0
   - mode 3 → q[7] toggles each cycle over 4 cycles
   - every run → `conflict_sticky`=1
4. Macro defined, CNT_W=2: 5 consecutive conflict cycles.
   - Expect `conflict_cnt` 1,2,3,3,3.
   - Then `err_clr` together with a conflict → cnt=1, sticky=1.
   - Then `err_clr` alone → cnt=0, sticky=0.
5. en=0 with s=FF, r=00 → q and pulses unchanged and no conflict. Repeat with s=r=FF → still no conflict.
6. Assert `rst` asynchronously between edges while q=AA.
   - Expect q=RESET_VAL before the next edge, with no `rose`/`fell` pulse.
   - Macro undefined → `conflict_cnt` reads 0 throughout.
